alu_sequencer: RTL

//  Multi-cycle controller that issues one 16-bit instruction at a time to the shared 16-bit ALU.
//  Per instruction it reads two registers, drives the ALU, captures the result and flags, and writes back.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_decode.sv | 69 ++++++
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode field values, PSR flag
// bit positions and the sequencer state encoding.
package alu_pkg;

    // op_hi values (instr[15:12])
    localparam logic [3:0] OPHI_REG   = 4'h0;
    localparam logic [3:0] OPHI_SHIFT = 4'h8;
    localparam logic [3:0] OPHI_ADDI  = 4'h5;
    localparam logic [3:0] OPHI_ADDUI = 4'h6;
    localparam logic [3:0] OPHI_ADDCI = 4'h7;
    localparam logic [3:0] OPHI_SUBI  = 4'h9;
    localparam logic [3:0] OPHI_CMPI  = 4'hB;

    // op_ext values (instr[7:4]) under OPHI_REG
    localparam logic [3:0] EXT_AND   = 4'h1;
    localparam logic [3:0] EXT_OR    = 4'h2;
    localparam logic [3:0] EXT_XOR   = 4'h3;
    localparam logic [3:0] EXT_NOT   = 4'h4;
    localparam logic [3:0] EXT_ADD   = 4'h5;
    localparam logic [3:0] EXT_ADDU  = 4'h6;
    localparam logic [3:0] EXT_ADDC  = 4'h7;
    localparam logic [3:0] EXT_ADDCU = 4'h8;
    localparam logic [3:0] EXT_SUB   = 4'h9;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_CMPU  = 4'hF;

    // op_ext values (instr[7:4]) under OPHI_SHIFT
    localparam logic [3:0] EXT_LSHI0 = 4'h0;
    localparam logic [3:0] EXT_LSHI1 = 4'h1;
    localparam logic [3:0] EXT_LSH   = 4'h4;
    localparam logic [3:0] EXT_RSH   = 4'h8;
    localparam logic [3:0] EXT_RSHI  = 4'h9;
    localparam logic [3:0] EXT_ALSH  = 4'hA;
    localparam logic [3:0] EXT_ARSH  = 4'hB;

    // PSR / ALU flag bit positions
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode for the ALU sequencer.
// Optional feature macro: ALU_SEQ_IMM_EN enables the immediate forms
// (ADDI, ADDUI, ADDCI, SUBI, CMPI); without it those op_hi values decode
// as illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [3:0]  op_hi,
    input  logic [3:0]  op_ext,
    output logic        legal,
    output logic        is_imm,
    output logic        is_cmp,
    output logic        sext,
    output logic [15:0] alu_opcode
);

    // Classify the instruction and build the opcode presented to the ALU
    always_comb begin
        legal  = 1'b0;
        is_imm = 1'b0;
        is_cmp = 1'b0;
        sext   = 1'b0;
        case (op_hi)
            OPHI_REG: begin
                case (op_ext)
                    EXT_AND, EXT_OR, EXT_XOR, EXT_NOT, EXT_ADD,
                    EXT_ADDU, EXT_ADDC, EXT_ADDCU, EXT_SUB: legal = 1'b1;
                    EXT_CMP, EXT_CMPU: begin
                        legal  = 1'b1;
                        is_cmp = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPHI_SHIFT: begin
                case (op_ext)
                    EXT_LSHI0, EXT_LSHI1, EXT_LSH, EXT_RSH,
                    EXT_RSHI, EXT_ALSH, EXT_ARSH: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
`ifdef ALU_SEQ_IMM_EN
            OPHI_ADDI, OPHI_ADDCI, OPHI_SUBI: begin
                legal  = 1'b1;
                is_imm = 1'b1;
                sext   = 1'b1;
            end
            OPHI_ADDUI: begin
                legal  = 1'b1;
                is_imm = 1'b1;
            end
            OPHI_CMPI: begin
                legal  = 1'b1;
                is_imm = 1'b1;
                sext   = 1'b1;
                is_cmp = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
        // Immediate forms carry no op_ext; register forms carry both fields
        if (is_imm) begin
            alu_opcode = {op_hi, 12'b0};
        end else begin
            alu_opcode = {op_hi, 4'b0, op_ext, 4'b0};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller issuing one instruction at a time to the shared
// ALU: IDLE -> READ -> EXEC -> WB, holding the PSR and feeding its carry
// back as ALU carry-in.
// Optional feature macro: ALU_SEQ_IMM_EN (immediate instruction forms,
// decoded in alu_decode).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [15:0]       alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal
);

    state_t            state;
    state_t            next_state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] res;
    logic [4:0]        flg;

    logic              legal;
    logic              is_imm;
    logic              is_cmp;
    logic              sext;
    logic [15:0]       dec_opcode;
    logic [DATA_W-1:0] imm_ext;
    logic              accept;

    alu_decode u_decode (
        .op_hi      (ir[15:12]),
        .op_ext     (ir[7:4]),
        .legal      (legal),
        .is_imm     (is_imm),
        .is_cmp     (is_cmp),
        .sext       (sext),
        .alu_opcode (dec_opcode)
    );

    assign imm_ext = {{(DATA_W-8){sext & ir[7]}}, ir[7:0]};
    assign accept  = instr_valid && (state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one fixed pass per accepted instruction
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = READ;
            READ:    next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: instruction, operands, ALU result/flags and PSR
    always_ff @(posedge clk) begin
        if (reset) begin
            ir  <= '0;
            opa <= '0;
            opb <= '0;
            res <= '0;
            flg <= '0;
            psr <= '0;
        end else begin
            if (accept) begin
                ir <= instr;
            end
            if (state == READ) begin
                opa <= rf_rdata_a;
                opb <= rf_rdata_b;
            end
            if (state == EXEC) begin
                res <= alu_c;
                flg <= alu_flags;
            end
            if (state == WB && legal) begin
                psr <= flg;
            end
        end
    end

    // Outputs: read addresses come straight from the offered instruction in
    // IDLE so the register file data is ready by the READ cycle
    always_comb begin
        instr_ready = 1'b0;
        rf_raddr_a  = ir[11:8];
        rf_raddr_b  = ir[3:0];
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = '0;
        alu_cin     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                rf_raddr_a  = instr[11:8];
                rf_raddr_b  = instr[3:0];
            end
            EXEC: begin
                alu_a      = opa;
                alu_b      = is_imm ? imm_ext : opb;
                alu_opcode = dec_opcode;
                alu_cin    = psr[FLAG_C];
            end
            WB: begin
                done    = 1'b1;
                illegal = !legal;
                if (legal && !is_cmp) begin
                    rf_we    = 1'b1;
                    rf_waddr = ir[11:8];
                    rf_wdata = res;
                end
            end
            default: ;
        endcase
    end

endmodule
